// File: rtl/mmio_console.sv
// mmio_console: memory-mapped console with a FIFO-fed 8N1 transmitter,
// a free-running cycle counter and a sticky end-of-test halt register.
module mmio_console #(
   parameter int CLKS_PER_BIT = 4,
   parameter int FIFO_AW      = 3
) (
   input  logic        CLK,
   input  logic        RSTn,
   input  logic        CSN,
   input  logic        WEN,
   input  logic [3:0]  BE,
   input  logic [11:0] ADDR,
   input  logic [31:0] DI,
   output logic [31:0] DOUT,
   output logic        TXD,
   output logic        HALT,
   output logic [31:0] HALT_CODE
);
   localparam int DEPTH = 1 << FIFO_AW;
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);
   localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;

   logic [7:0] mem [DEPTH];
   logic [FIFO_AW-1:0] wp, rp;
   logic [FIFO_AW:0] count;
   logic [1:0] state;
   logic [BW-1:0] baud;
   logic [2:0] nbit;
   logic [7:0] sh;
   logic [31:0] cycle, bmask, rdata;
   logic ovf, hit, wr, rd, empty, full, busy, pop, push_req, push_ok, ovf_clr, cyc_wr, halt_wr, bit_end;
   logic unused_addr;

   assign unused_addr = ^ADDR[1:0];
   assign hit = ADDR[11:4] == 8'd0;
   assign wr = !CSN && !WEN && hit;
   assign rd = !CSN && WEN;
   assign empty = count == '0;
   assign full = count == FULL_CNT;
   assign busy = state != IDLE;
   assign pop = !busy && !empty;
   assign push_req = wr && ADDR[3:2] == 2'd0 && BE[0];
   // A pop on the same edge frees a slot, so a push into a full FIFO still lands
   assign push_ok = push_req && (!full || pop);
   assign ovf_clr = wr && ADDR[3:2] == 2'd1 && BE[0] && DI[3];
   assign cyc_wr = wr && ADDR[3:2] == 2'd2 && |BE;
   assign halt_wr = wr && ADDR[3:2] == 2'd3 && |BE;
   assign bit_end = busy && baud == LAST;
   assign bmask = {{8{BE[3]}}, {8{BE[2]}}, {8{BE[1]}}, {8{BE[0]}}};

   always_comb
      rdata = !hit ? '0 :
              ADDR[3:2] == 2'd1 ? {28'd0, ovf, busy, full, empty} :
              ADDR[3:2] == 2'd2 ? cycle :
              ADDR[3:2] == 2'd3 ? HALT_CODE : '0;

   always_ff @(posedge CLK)
      if (RSTn && push_ok) mem[wp] <= DI[7:0];

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         DOUT <= '0;
         HALT <= 1'b0;
         HALT_CODE <= '0;
         cycle <= '0;
         ovf <= 1'b0;
         wp <= '0;
         rp <= '0;
         count <= '0;
      end else begin
         if (rd) DOUT <= rdata;
         if (halt_wr) begin
            HALT <= 1'b1;
            HALT_CODE <= DI & bmask;
         end
         cycle <= cyc_wr ? (DI & bmask) | (cycle & ~bmask) : cycle + 32'd1;
         ovf <= (push_req && !push_ok) || (ovf && !ovf_clr);
         if (push_ok) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         count <= count + (FIFO_AW + 1)'(push_ok) - (FIFO_AW + 1)'(pop);
      end
   end

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         state <= IDLE;
         TXD <= 1'b1;
         baud <= '0;
         nbit <= '0;
         sh <= '0;
      end else begin
         baud <= (!busy || bit_end) ? '0 : baud + 1'b1;
         if (!busy) begin
            if (pop) begin
               state <= START;
               sh <= mem[rp];
               TXD <= 1'b0;
            end
         end else if (bit_end) begin
            if (state == START) begin
               state <= DATA;
               TXD <= sh[0];
               nbit <= '0;
            end else if (state == DATA) begin
               sh <= sh >> 1;
               nbit <= nbit + 1'b1;
               state <= nbit == 3'd7 ? STOP : DATA;
               TXD <= nbit == 3'd7 ? 1'b1 : sh[1];
            end else begin
               state <= IDLE;
            end
         end
      end
   end
endmodule

// File: tb/tb_mmio_console.sv
// tb_mmio_console: randomized scoreboard bench; a queue-based reference model predicts
// read data and transmitted bytes, separate monitors check DOUT, HALT and the TXD waveform.
module tb_mmio_console;
   localparam int N = 4;
   localparam int DEPTH = 8;
   localparam int FRAME = 10 * N + 1;

   logic clk = 1'b1;
   logic rstn, csn, wen;
   logic [3:0] be;
   logic [11:0] addr;
   logic [31:0] di, dout, halt_code;
   logic txd, halt;

   int checks = 0;
   int passes = 0;

   logic [31:0] exp_rd[$];
   logic [7:0] exp_tx[$];
   logic [7:0] q[$];
   int busy_left = 0;
   logic m_ovf = 1'b0;
   logic m_halt = 1'b0;
   logic [31:0] m_cyc = '0;
   logic [31:0] m_code = '0;

   mmio_console #(.CLKS_PER_BIT(N), .FIFO_AW(3)) dut (
      .CLK(clk), .RSTn(rstn), .CSN(csn), .WEN(wen), .BE(be), .ADDR(addr), .DI(di),
      .DOUT(dout), .TXD(txd), .HALT(halt), .HALT_CODE(halt_code)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Reference model: FIFO as a byte queue, transmitter as a busy-cycle countdown
   task automatic model_step();
      logic [31:0] bm, rv;
      bit w, r, hit, pop, ovf_set;
      int sel;
      bm = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      w = !csn && !wen;
      r = !csn && wen;
      hit = addr[11:4] == 8'd0;
      sel = int'(addr[3:2]);
      if (!rstn) begin
         exp_rd.push_back(32'd0);
         q.delete();
         exp_tx.delete();
         busy_left = 0;
         m_ovf = 1'b0;
         m_cyc = '0;
         m_halt = 1'b0;
         m_code = '0;
         return;
      end
      if (r) begin
         rv = '0;
         if (hit && sel == 1) rv = {28'd0, m_ovf, busy_left > 0, q.size() == DEPTH, q.size() == 0};
         if (hit && sel == 2) rv = m_cyc;
         if (hit && sel == 3) rv = m_code;
         exp_rd.push_back(rv);
      end
      pop = busy_left == 0 && q.size() > 0;
      if (busy_left > 0) busy_left--;
      if (pop) begin
         exp_tx.push_back(q.pop_front());
         busy_left = 10 * N;
      end
      ovf_set = 1'b0;
      if (w && hit && sel == 0 && be[0]) begin
         if (q.size() < DEPTH) q.push_back(di[7:0]);
         else ovf_set = 1'b1;
      end
      if (ovf_set) m_ovf = 1'b1;
      else if (w && hit && sel == 1 && be[0] && di[3]) m_ovf = 1'b0;
      m_cyc = (w && hit && sel == 2 && be != 0) ? (di & bm) | (m_cyc & ~bm) : m_cyc + 32'd1;
      if (w && hit && sel == 3 && be != 0) begin
         m_halt = 1'b1;
         m_code = di & bm;
      end
   endtask

   task automatic cyc(input bit r, input bit c, input bit w, input logic [3:0] b,
                      input logic [11:0] a, input logic [31:0] d);
      @(negedge clk);
      rstn = r; csn = c; wen = w; be = b; addr = a; di = d;
      model_step();
   endtask

   task automatic wr_reg(input logic [11:0] a, input logic [31:0] d, input logic [3:0] b);
      cyc(1, 0, 0, b, a, d);
   endtask

   task automatic rd_reg(input logic [11:0] a);
      cyc(1, 0, 1, 4'($urandom), a, $urandom);
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1, 1, 1'($urandom), 4'($urandom), 12'($urandom), $urandom);
   endtask

   // Read/reset monitor: every read or reset edge must present the predicted DOUT
   initial forever begin
      bit take;
      @(posedge clk);
      take = !rstn || (!csn && wen);
      #1;
      if (take) begin
         if (exp_rd.size() == 0) begin
            checks++;
            $display("FAIL dout_unexpected: got %h with no prediction queued", dout);
         end else check("dout", dout, exp_rd.pop_front());
      end
      check("halt", {31'd0, halt}, {31'd0, m_halt});
      check("halt_code", halt_code, m_code);
   end

   // TXD monitor: checks every sample of each frame plus the trailing idle cycle
   initial forever begin
      bit ab, known;
      logic [7:0] eb, got;
      logic es;
      int bad;
      @(posedge clk);
      #1;
      if (txd === 1'b0) begin
         ab = 1'b0;
         bad = 0;
         got = '0;
         known = exp_tx.size() > 0;
         eb = known ? exp_tx[0] : 8'h00;
         if (!known) begin
            checks++;
            $display("FAIL tx_unexpected: start bit seen, expected no frame");
         end
         for (int s = 1; s <= 10 * N; s++) begin
            @(posedge clk);
            if (!rstn) begin
               ab = 1'b1;
               break;
            end
            #1;
            es = s < N ? 1'b0 : s < 9 * N ? eb[(s - N) / N] : 1'b1;
            if (txd !== es) bad++;
            if (s >= N && s < 9 * N && (s % N) == N / 2) got[(s - N) / N] = txd;
         end
         if (!ab && known) begin
            check("tx_byte", {24'd0, got}, {24'd0, eb});
            check("tx_shape_errs", bad, 0);
            void'(exp_tx.pop_front());
         end
      end
   end

   initial begin
      int op, sel;
      logic [11:0] a;
      logic [3:0] b;
      bit w;
      rstn = 1'b0; csn = 1'b1; wen = 1'b1; be = '0; addr = '0; di = '0;
      repeat (3) cyc(0, 0, 0, 4'hF, 12'h00C, 32'h1234_5678);
      rd_reg(12'h004);
      @(posedge clk);
      #1;
      check("txd_idle_after_reset", {31'd0, txd}, 32'd1);
      wr_reg(12'h000, 32'h0000_00A5, 4'h1);
      idle(2);
      rd_reg(12'h004);
      idle(FRAME + 4);
      wr_reg(12'h000, 32'h0000_005A, 4'h0);
      rd_reg(12'h000);
      rd_reg(12'h004);
      for (int i = 0; i < 9; i++) wr_reg(12'h000, $urandom, 4'h1);
      rd_reg(12'h004);
      for (int i = 0; i < 9; i++) wr_reg(12'h000, $urandom, 4'h1);
      rd_reg(12'h004);
      wr_reg(12'h004, 32'h0000_0008, 4'h1);
      rd_reg(12'h004);
      idle(10 * FRAME);
      wr_reg(12'h008, 32'hFFFF_FFFE, 4'hF);
      idle(1);
      rd_reg(12'h008);
      rd_reg(12'h008);
      wr_reg(12'h00C, 32'hDEAD_BEEF, 4'hF);
      @(posedge clk);
      #1;
      check("halt_set", {31'd0, halt}, 32'd1);
      check("halt_code_set", halt_code, 32'hDEAD_BEEF);
      rd_reg(12'h010);
      wr_reg(12'h000, 32'h0000_00A5, 4'h1);
      idle(4 * N + 1);
      cyc(0, 1, 1, 4'h0, 12'h000, 32'h0);
      @(posedge clk);
      #1;
      check("txd_after_midframe_reset", {31'd0, txd}, 32'd1);
      rd_reg(12'h004);
      idle(12 * N);
      for (int i = 0; i < 1500; i++) begin
         op = $urandom_range(0, 99);
         if (op < 1) cyc(0, 1'($urandom), 1'($urandom), 4'($urandom), 12'($urandom), $urandom);
         else if (op < 35) idle(1);
         else begin
            sel = $urandom_range(0, 5);
            a = sel < 4 ? {8'd0, 2'(sel), 2'($urandom)} :
                sel == 4 ? {8'($urandom_range(1, 255)), 4'($urandom)} : 12'h000;
            w = 1'($urandom);
            b = 4'($urandom);
            if (!w && (sel == 2 || sel == 3)) b = 4'hF;
            cyc(1, 0, w, b, a, $urandom);
         end
      end
      idle((DEPTH + 2) * FRAME + 20);
      @(posedge clk);
      #2;
      check("rd_queue_left", exp_rd.size(), 0);
      check("tx_queue_left", exp_tx.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/mmio_console.md
MMIO_CONSOLE -- requirements
Module: mmio_console

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4, clock cycles per serial bit; legal values >= 2.
REQ-002 Parameter FIFO_AW, default 3, log2 of the transmit FIFO depth (depth 8 at default).
REQ-003 CLK  input  1  single clock; all state changes on the rising edge.
REQ-004 RSTn  input  1  reset, synchronous, active-low.
REQ-005 CSN  input  1  chip select from the core D-memory port, active-low.
REQ-006 WEN  input  1  write enable, active-low; 1 = read.
REQ-007 BE  input  4  byte enables, active-high; BE[i] qualifies DI[8i+7:8i].
REQ-008 ADDR  input  12  byte address; only ADDR[3:2] decoded, ADDR[11:4] must be 0 for a hit.
REQ-009 DI  input  32  write data from the core.
REQ-010 DOUT  output  32  registered read data to the core.
REQ-011 TXD  output  1  serial 8N1 output, idle high.
REQ-012 HALT  output  1  sticky end-of-test flag.
REQ-013 HALT_CODE  output  32  value written to the HALT register.

Function
REQ-014 Access = CSN==0 sampled at a rising edge; no access when CSN==1 (DOUT holds its value).
REQ-015 Read latency is one cycle: on a read access, DOUT takes the addressed value at that edge and holds until the next read access.
REQ-016 Register map: 0x0 TXDATA, 0x4 STATUS, 0x8 CYCLE, 0xC HALT; any non-hit address reads 0 and ignores writes.
REQ-017 TXDATA write with BE[0]=1 pushes DI[7:0] into the FIFO; BE[0]=0 performs no push; TXDATA reads return 0.
REQ-018 Push while full (after any same-cycle pop) is dropped and sets sticky OVF.
REQ-019 STATUS read = {28'b0, OVF, BUSY, FULL, EMPTY} (bits 3..0); BUSY = serializer not in IDLE.
REQ-020 STATUS write with BE[0]=1 and DI[3]=1 clears OVF; a same-cycle overflow wins (OVF stays 1).
REQ-021 CYCLE is a free-running 32-bit counter incrementing every cycle, wrapping 0xFFFFFFFF -> 0; a write loads DI per enabled byte, and the increment resumes from the loaded value the next cycle.
REQ-022 HALT write (any BE nonzero) sets HALT=1 and HALT_CODE=DI (byte-masked onto 0); later writes update HALT_CODE; HALT remains 1 until reset.
REQ-023 FIFO: circular buffer, FIFO_AW-bit pointers plus a count; EMPTY when count==0, FULL when count==2^FIFO_AW; pointers wrap modulo depth.
REQ-024 Simultaneous push and pop: count unchanged, both take effect, even when full or empty-at-push cannot pop.
REQ-025 Serializer states IDLE, START, DATA, STOP; IDLE with FIFO non-empty pops one byte on that edge and enters START.
REQ-026 START drives TXD=0, DATA drives 8 bits LSB first, STOP drives TXD=1; each bit lasts exactly CLKS_PER_BIT cycles via a baud counter.
REQ-027 After STOP: IDLE for one cycle minimum, then the next byte if available (frame period = 10*CLKS_PER_BIT+1 cycles back-to-back).
REQ-028 TXD is registered; TXD=1 in IDLE.

Reset
REQ-029 With RSTn==0 at an edge: DOUT=0, TXD=1, HALT=0, HALT_CODE=0, CYCLE=0, OVF=0, FIFO empty, serializer IDLE, baud counter 0.
REQ-030 Reset mid-frame aborts the frame: TXD=1 from the next edge; queued bytes are discarded.
REQ-031 Reset overrides any same-cycle access.

Verification
REQ-032 Reset release, then read STATUS -> DOUT=0x00000001 next cycle; TXD=1.
REQ-033 Write 0x000000A5 to 0x0 with BE=0001 -> TXD low for 4 cycles, bits 1,0,1,0,0,1,0,1 for 4 cycles each, high for 4 cycles; BUSY=1 throughout the frame.
REQ-034 Nine pushes with the serializer stalled by back-to-back writes (depth 8, first popped) -> no OVF; a further 9 rapid pushes -> STATUS bit3=1; STATUS write DI=0x8 -> bit3=0.
REQ-035 Write CYCLE=0xFFFFFFFE, read twice in back-to-back cycles -> reads 0xFFFFFFFF then 0x00000000 (wrap).
REQ-036 Write 0xDEADBEEF to 0xC -> HALT=1, HALT_CODE=0xDEADBEEF; read 0x10 -> DOUT=0.
REQ-037 Assert RSTn=0 during DATA bit 3 -> TXD=1 next edge, STATUS reads 0x1 after release.
